ps2_keyboard_rx: RTL

- Receives PS/2 device-to-host frames on kclk_i/kdata_i and checks framing and odd parity.
- Buffers valid scan codes in a small first-word-fall-through FIFO.
- Sits directly upstream of the riscv_unit keyboard peripheral; the peripheral reads data_o/valid_o and pops with rd_i.
- Reports errors through sticky flags that software clears.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_keyboard_rx_if.sv | 32 +++
 rtl/ps2_scan_fifo.sv | 66 ++++++
 rtl/ps2_keyboard_rx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_t  - receiver frame FSM states
//   PS2_*        - frame format constants
//   odd_parity   - parity bit a well-formed frame carries for a data byte
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   localparam int unsigned PS2_DATA_BITS = 8;
   localparam logic        PS2_START_BIT = 1'b0;
   localparam logic        PS2_STOP_BIT  = 1'b1;

   // Odd parity: data bits plus the parity bit contain an odd number of ones.
   function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Scan-code read bus and error/status bus between the PS/2 receiver and the
// keyboard peripheral.
//   master : receiver side (drives data/valid/level and error flags)
//   slave  : peripheral side (drives rd_i pop strobe and clr_err_i)
interface ps2_keyboard_rx_if
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
);

   localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   logic                     rd_i;
   logic [PS2_DATA_BITS-1:0] data_o;
   logic                     valid_o;
   logic [LEVEL_W-1:0]       level_o;
   logic                     clr_err_i;
   logic                     parity_err_o;
   logic                     frame_err_o;
   logic                     overflow_o;

   modport master (
      input  rd_i, clr_err_i,
      output data_o, valid_o, level_o, parity_err_o, frame_err_o, overflow_o
   );

   modport slave (
      output rd_i, clr_err_i,
      input  data_o, valid_o, level_o, parity_err_o, frame_err_o, overflow_o
   );

endinterface

// File: rtl/ps2_scan_fifo.sv
// First-word-fall-through FIFO for 8-bit scan codes.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   push/wdata : write request and byte; accepted when not full or when a pop
//                happens in the same cycle
//   pop        : read request; ignored while empty
//   rdata      : head entry, read straight from storage
//   full/empty/level : occupancy status, level ranges 0..DEPTH
module ps2_scan_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [PS2_DATA_BITS-1:0]   wdata,
   input  logic                       pop,
   output logic [PS2_DATA_BITS-1:0]   rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned LEVEL_W = PTR_W + 1;

   logic [PS2_DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [LEVEL_W-1:0]       count;
   logic                     pop_ok;
   logic                     push_ok;

   assign empty   = (count == '0);
   assign full    = (count == LEVEL_W'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + LEVEL_W'(1);
            2'b01:   count <= count - LEVEL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver.
//   clk_i, rst_i : system clock, asynchronous active-low reset
//   kclk_i       : PS/2 clock (asynchronous)
//   kdata_i      : PS/2 data (asynchronous)
//   bus          : scan-code FIFO read port (data_o/valid_o/level_o/rd_i) and
//                  sticky error flags with clr_err_i
// Frames are start(0), 8 data bits LSB first, odd parity, stop(1). Good bytes
// go into a FWFT FIFO; bad frames, timeouts and drops set sticky flags.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              kclk_i,
   input  logic              kdata_i,
   ps2_keyboard_rx_if.master bus
);

   localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   // Synchronisers plus history stage; reset to the idle-high line level so
   // leaving reset never fakes a falling edge.
   logic kclk_s1, kclk_s2, kclk_hist;
   logic kdata_s1, kdata_s2, kdata_hist;
   logic fe;
   logic sbit;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         kclk_s1    <= 1'b1;
         kclk_s2    <= 1'b1;
         kclk_hist  <= 1'b1;
         kdata_s1   <= 1'b1;
         kdata_s2   <= 1'b1;
         kdata_hist <= 1'b1;
      end else begin
         kclk_s1    <= kclk_i;
         kclk_s2    <= kclk_s1;
         kclk_hist  <= kclk_s2;
         kdata_s1   <= kdata_i;
         kdata_s2   <= kdata_s1;
         kdata_hist <= kdata_s2;
      end
   end

   assign fe   = kclk_hist & ~kclk_s2;
   // Data is stable for half a bit period around the fall, so the history
   // stage is a safe sample point.
   assign sbit = kdata_hist;

   ps2_state_t               state;
   logic [2:0]               bit_cnt;
   logic [PS2_DATA_BITS-1:0] shreg;
   logic                     par_bit;
   logic [TO_W-1:0]          to_cnt;
   logic                     push;
   logic [PS2_DATA_BITS-1:0] push_data;
   logic                     parity_err;
   logic                     frame_err;
   logic                     overflow;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic [PS2_DATA_BITS-1:0] fifo_rdata;
   logic [LEVEL_W-1:0]       fifo_level;
   logic                     pop_ok;
   logic                     overflow_set;

   assign pop_ok       = bus.rd_i & ~fifo_empty;
   assign overflow_set = push & fifo_full & ~pop_ok;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         to_cnt     <= '0;
         push       <= 1'b0;
         push_data  <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         push <= 1'b0;

         // Clear first; any set below in the same cycle takes precedence.
         if (bus.clr_err_i) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
         end
         if (overflow_set) begin
            overflow <= 1'b1;
         end

         if (state == IDLE || fe) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         if (state != IDLE && !fe && to_cnt == TO_LAST) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end else if (fe) begin
            unique case (state)
               IDLE: begin
                  if (sbit == PS2_START_BIT) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg   <= {sbit, shreg[PS2_DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_bit <= sbit;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (sbit != PS2_STOP_BIT) begin
                     frame_err <= 1'b1;
                  end else if (par_bit != odd_parity(shreg)) begin
                     parity_err <= 1'b1;
                  end else begin
                     push      <= 1'b1;
                     push_data <= shreg;
                  end
               end
            endcase
         end
      end
   end

   ps2_scan_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (push),
      .wdata (push_data),
      .pop   (bus.rd_i),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign bus.data_o       = fifo_rdata;
   assign bus.valid_o      = ~fifo_empty;
   assign bus.level_o      = fifo_level;
   assign bus.parity_err_o = parity_err;
   assign bus.frame_err_o  = frame_err;
   assign bus.overflow_o   = overflow;

endmodule
